// File: rtl/alu_rr_scheduler_if.sv
// Requester, ALU and response signals of the shared-ALU scheduler.
// master = scheduler side, slave = requesters / ALU / response consumer.
interface alu_rr_scheduler_if #(
   parameter int NUM_REQ = 4
);
   localparam int IDW = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [2*NUM_REQ-1:0] req_opcode;
   logic [4*NUM_REQ-1:0] req_A;
   logic [4*NUM_REQ-1:0] req_B;
   logic [1:0]           alu_opcode;
   logic [3:0]           alu_A;
   logic [3:0]           alu_B;
   logic [4:0]           alu_C;
   logic                 rsp_valid;
   logic [IDW-1:0]       rsp_id;
   logic [4:0]           rsp_data;
   logic                 rsp_ready;

   modport master (
      input  req_valid, req_opcode, req_A, req_B, alu_C, rsp_ready,
      output req_ready, alu_opcode, alu_A, alu_B, rsp_valid, rsp_id, rsp_data
   );

   modport slave (
      output req_valid, req_opcode, req_A, req_B, alu_C, rsp_ready,
      input  req_ready, alu_opcode, alu_A, alu_B, rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one registered 4-bit ALU among NUM_REQ requesters.
// Optional ALU_SCHED_STATS_EN adds a saturating completed-operation counter op_count.
module alu_rr_scheduler #(
   parameter int NUM_REQ = 4
) (
   input  logic               clk,
   input  logic               reset,
`ifdef ALU_SCHED_STATS_EN
   output logic [15:0]        op_count,
`endif
   alu_rr_scheduler_if.master bus
);
   localparam int IDW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

   state_t                  state, state_nx;
   logic [IDW-1:0]          rr_ptr, grp_id, gnt_id, ptr_nx;
   logic                    gnt_any;
   logic                    rsp_hs;
   int                      idx;
   logic [NUM_REQ-1:0][1:0] op_v;
   logic [NUM_REQ-1:0][3:0] a_v, b_v;

   assign op_v   = bus.req_opcode;
   assign a_v    = bus.req_A;
   assign b_v    = bus.req_B;
   assign rsp_hs = bus.rsp_valid & bus.rsp_ready;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = '0;
      idx     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!gnt_any && bus.req_valid[idx[IDW-1:0]]) begin
            gnt_any = 1'b1;
            gnt_id  = idx[IDW-1:0];
         end
      end
   end

   assign ptr_nx = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

   always_comb begin
      state_nx      = state;
      bus.req_ready = '0;
      unique case (state)
         IDLE: if (gnt_any) begin
            bus.req_ready[gnt_id] = 1'b1;
            state_nx              = EXEC;
         end
         EXEC:    state_nx = CAPT;
         CAPT:    state_nx = RESP;
         RESP:    if (rsp_hs) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rr_ptr         <= '0;
         grp_id         <= '0;
         bus.alu_opcode <= '0;
         bus.alu_A      <= '0;
         bus.alu_B      <= '0;
         bus.rsp_valid  <= 1'b0;
         bus.rsp_id     <= '0;
         bus.rsp_data   <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (gnt_any) begin
               bus.alu_opcode <= op_v[gnt_id];
               bus.alu_A      <= a_v[gnt_id];
               bus.alu_B      <= b_v[gnt_id];
               grp_id         <= gnt_id;
               rr_ptr         <= ptr_nx;
            end
            // ALU output registered at the end of EXEC is valid here
            CAPT: begin
               bus.rsp_data  <= bus.alu_C;
               bus.rsp_id    <= grp_id;
               bus.rsp_valid <= 1'b1;
            end
            RESP: if (rsp_hs) bus.rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

`ifdef ALU_SCHED_STATS_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         op_count <= '0;
      else if (rsp_hs && op_count != 16'hFFFF)
         op_count <= op_count + 16'd1;
   end
`endif
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Directed + random bench for alu_rr_scheduler with a registered ALU stand-in
// and a round-robin reference model.
module tb_alu_rr_scheduler;
   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_fail = 0;
   int   m_ptr;
   int   m_ops;
`ifdef ALU_SCHED_STATS_EN
   logic [15:0] op_count;
`endif

   alu_rr_scheduler_if #(.NUM_REQ(4)) bus ();

   alu_rr_scheduler #(.NUM_REQ(4)) dut (
      .clk   (clk),
      .reset (reset),
`ifdef ALU_SCHED_STATS_EN
      .op_count (op_count),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] alu_ref(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
      case (o)
         2'd0:    return {1'b0, x} + {1'b0, y};
         2'd1:    return {1'b0, x} - {1'b0, y};
         2'd2:    return {1'b0, x & y};
         default: return (x < y) ? 5'd1 : 5'd0;
      endcase
   endfunction

   // Shared ALU: registered output, async reset (active-high ~reset at the subsystem top)
   logic [4:0] alu_c_q;
   always_ff @(posedge clk or negedge reset)
      if (!reset) alu_c_q <= '0;
      else        alu_c_q <= alu_ref(bus.alu_opcode, bus.alu_A, bus.alu_B);
   assign bus.alu_C = alu_c_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [1:0] o, input logic [3:0] x, input logic [3:0] y);
      bus.req_valid[i]          = 1'b1;
      bus.req_opcode[2*i +: 2]  = o;
      bus.req_A[4*i +: 4]       = x;
      bus.req_B[4*i +: 4]       = y;
   endtask

   // One full operation starting at a negedge in IDLE; ends at the negedge back in IDLE.
   task automatic transact(input int bp, input bit keep, input int late);
      int g;
      logic [1:0] o;
      logic [3:0] x, y;
      logic [4:0] e;
      g = -1;
      for (int k = 0; k < 4; k++)
         if (g < 0 && bus.req_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      if (g < 0) begin
         n_fail++;
         $error("FAIL transact: no requester valid");
         return;
      end
      o = bus.req_opcode[2*g +: 2];
      x = bus.req_A[4*g +: 4];
      y = bus.req_B[4*g +: 4];
      e = alu_ref(o, x, y);
      bus.rsp_ready = (bp == 0);
      #1;
      check("grant", 32'(bus.req_ready), 32'd1 << g);
      @(negedge clk);
      if (!keep) bus.req_valid[g] = 1'b0;
      check("exec_ready", 32'(bus.req_ready), 0);
      check("alu_opcode", 32'(bus.alu_opcode), 32'(o));
      check("alu_A", 32'(bus.alu_A), 32'(x));
      check("alu_B", 32'(bus.alu_B), 32'(y));
      @(negedge clk);
      check("capt_valid", 32'(bus.rsp_valid), 0);
      @(negedge clk);
      if (late >= 0) set_req(late, 2'd2, 4'hA, 4'h6);
      #1;
      check("rsp_valid", 32'(bus.rsp_valid), 1);
      check("rsp_id", 32'(bus.rsp_id), 32'(g));
      check("rsp_data", 32'(bus.rsp_data), 32'(e));
      for (int c = 0; c < bp; c++) begin
         @(negedge clk);
         check("bp_valid", 32'(bus.rsp_valid), 1);
         check("bp_id", 32'(bus.rsp_id), 32'(g));
         check("bp_data", 32'(bus.rsp_data), 32'(e));
         check("bp_ready", 32'(bus.req_ready), 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      check("rsp_done", 32'(bus.rsp_valid), 0);
      m_ptr = (g + 1) % 4;
      m_ops++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      reset          = 1'b0;
      bus.req_valid  = '0;
      bus.req_opcode = '0;
      bus.req_A      = '0;
      bus.req_B      = '0;
      bus.rsp_ready  = 1'b1;
      m_ptr = 0;
      m_ops = 0;
      #1;
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_id", 32'(bus.rsp_id), 0);
      check("rst_rsp_data", 32'(bus.rsp_data), 0);
      check("rst_alu", {22'd0, bus.alu_opcode, bus.alu_A, bus.alu_B}, 0);
      check("rst_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("idle_ready", 32'(bus.req_ready), 0);
      check("idle_valid", 32'(bus.rsp_valid), 0);

      // Round-robin with all requesters held valid: 0,1,2,3,0
      for (int i = 0; i < 4; i++) set_req(i, 2'd0, 4'(i), 4'd1);
      repeat (5) transact(0, 1'b1, -1);
      bus.req_valid = '0;

      // Single request 3+5
      set_req(0, 2'd0, 4'd3, 4'd5);
      transact(0, 1'b0, -1);

      // Pointer skip to req3, then req0+req3 picks req0
      set_req(3, 2'd3, 4'd5, 4'd0);
      transact(0, 1'b0, -1);
      set_req(0, 2'd1, 4'd2, 4'd7);
      set_req(3, 2'd0, 4'd15, 4'd15);
      transact(0, 1'b0, -1);
      transact(0, 1'b0, -1);

      // Backpressure on req2 with a late req1 arriving in RESP
      set_req(2, 2'd3, 4'd0, 4'd4);
      transact(10, 1'b0, 1);
      transact(0, 1'b0, -1);

      // Random traffic obeying the hold-until-accepted rule
      for (int it = 0; it < 24; it++) begin
         for (int i = 0; i < 4; i++)
            if (!bus.req_valid[i] && $urandom_range(0, 1) == 1)
               set_req(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         if (bus.req_valid == 4'b0) begin
            r = $urandom_range(0, 3);
            set_req(r, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         end
         transact($urandom_range(0, 3), 1'b0, -1);
      end
      bus.req_valid = '0;

      // Async reset during EXEC; pointer before reset would favour req3
      set_req(1, 2'd1, 4'd9, 4'd2);
      #1;
      check("mid_grant", 32'(bus.req_ready), 32'b0010);
      @(negedge clk);
      bus.req_valid = '0;
      check("mid_alu_A", 32'(bus.alu_A), 9);
      #2 reset = 1'b0;
      #1;
      check("mid_rsp_valid", 32'(bus.rsp_valid), 0);
      check("mid_alu", {22'd0, bus.alu_opcode, bus.alu_A, bus.alu_B}, 0);
      check("mid_ready", 32'(bus.req_ready), 0);
      @(negedge clk);
      reset = 1'b1;
      m_ptr = 0;
      m_ops = 0;
      repeat (3) begin
         @(negedge clk);
         check("no_stale", 32'(bus.rsp_valid), 0);
      end
      set_req(1, 2'd0, 4'd6, 4'd7);
      set_req(3, 2'd2, 4'd12, 4'd10);
      transact(0, 1'b0, -1);
      transact(1, 1'b0, -1);

`ifdef ALU_SCHED_STATS_EN
      set_req(0, 2'd0, 4'd1, 4'd1);
      transact(0, 1'b0, -1);
      check("op_count", 32'(op_count), 32'(m_ops));
      reset = 1'b0;
      #1;
      check("op_count_rst", 32'(op_count), 0);
      @(negedge clk);
      reset = 1'b1;
      m_ptr = 0;
      force dut.op_count = 16'hFFFE;
      #1 release dut.op_count;
      set_req(2, 2'd0, 4'd2, 4'd2);
      transact(0, 1'b0, -1);
      set_req(2, 2'd0, 4'd3, 4'd2);
      transact(0, 1'b0, -1);
      check("op_count_sat", 32'(op_count), 32'hFFFF);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
